// File: rtl/rcv_ctrl.sv
// Receive control for the serial receiver: synchronises the line, detects the start
// edge and sequences timer, stop-bit check and buffer load, with ready/error status.
module rcv_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic serial_in,
  input  logic packet_done,
  input  logic stop_bit,
  input  logic data_read,
  output logic sbc_clear,
  output logic enable_timer,
  output logic load_buffer,
  output logic data_ready,
  output logic framing_error,
  output logic overrun_error
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    RECEIVE  = 3'd2,
    STOP_CHK = 3'd3,
    LOAD     = 3'd4
  } state_t;

  state_t                 state_r;
  state_t                 next_state_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   start_det_s;

  // Line synchroniser plus edge flop; both reset to the idle-high line level.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_r <= '1;
      prev_r <= 1'b1;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], serial_in};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign start_det_s = prev_r & ~sync_r[SYNC_STAGES-1];

  // Packet sequencing state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; falling edges outside IDLE are data bits and are ignored.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_det_s) next_state_s = START;
        else             next_state_s = IDLE;
      end
      START:   next_state_s = RECEIVE;
      RECEIVE: begin
        if (packet_done) next_state_s = STOP_CHK;
        else             next_state_s = RECEIVE;
      end
      STOP_CHK: begin
        if (stop_bit) next_state_s = LOAD;
        else          next_state_s = IDLE;
      end
      LOAD:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Control strobes are flopped from the next state so they line up with the state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sbc_clear    <= 1'b0;
      enable_timer <= 1'b0;
      load_buffer  <= 1'b0;
    end else begin
      sbc_clear    <= (next_state_s == START);
      enable_timer <= (next_state_s == RECEIVE);
      load_buffer  <= (next_state_s == LOAD);
    end
  end

  // Framing status: sticky from a bad stop bit until the next packet starts.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      framing_error <= 1'b0;
    end else if ((state_r == STOP_CHK) && !stop_bit) begin
      framing_error <= 1'b1;
    end else if (next_state_s == START) begin
      framing_error <= 1'b0;
    end else begin
      framing_error <= framing_error;
    end
  end

  // Buffer status; a load coinciding with data_read hands over cleanly (no overrun).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
    end else if (state_r == LOAD) begin
      data_ready <= 1'b1;
      if (data_ready && !data_read) overrun_error <= 1'b1;
      else if (data_read)           overrun_error <= 1'b0;
      else                          overrun_error <= overrun_error;
    end else if (data_read) begin
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      data_ready    <= data_ready;
      overrun_error <= overrun_error;
    end
  end

endmodule

// File: tb/tb_rcv_ctrl.sv
// Bench for rcv_ctrl: directed scenarios plus random traffic, checked every cycle
// against a timeline model of packets (start cycle, done cycle) and status flags.
module tb_rcv_ctrl;
  localparam int S = 2;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic serial_in = 1'b1;
  logic packet_done = 1'b0;
  logic stop_bit = 1'b1;
  logic data_read = 1'b0;
  logic sbc_clear, enable_timer, load_buffer, data_ready, framing_error, overrun_error;

  int checks = 0;
  int failures = 0;
  int cnt_sbc = 0, cnt_en = 0, cnt_load = 0;

  rcv_ctrl #(.SYNC_STAGES(S)) dut (
    .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .packet_done(packet_done),
    .stop_bit(stop_bit), .data_read(data_read), .sbc_clear(sbc_clear),
    .enable_timer(enable_timer), .load_buffer(load_buffer), .data_ready(data_ready),
    .framing_error(framing_error), .overrun_error(overrun_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: line samples, the current packet's START cycle t0 and packet_done cycle td.
  bit hist[$];
  int cyc;
  bit busy;
  int t0, td;
  bit m_fe, m_dr, m_ov;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i <= S; i++) hist.push_back(1'b1);
    cyc = 0; busy = 0; t0 = 0; td = -1;
    m_fe = 0; m_dr = 0; m_ov = 0;
  endtask

  task automatic model_step();
    bit sd, ld;
    sd = hist[S] & ~hist[S-1];
    ld = busy && (td >= 0) && (cyc == td + 2);
    if (busy && (td >= 0) && (cyc == td + 1)) begin
      if (!stop_bit) begin m_fe = 1; busy = 0; end
    end else if (ld) begin
      busy = 0;
    end else if (busy && (cyc > t0) && (td < 0) && packet_done) begin
      td = cyc;
    end else if (!busy && sd) begin
      busy = 1; t0 = cyc + 1; td = -1; m_fe = 0;
    end
    if (ld) begin
      if (m_dr && !data_read) m_ov = 1;
      else if (data_read)     m_ov = 0;
      m_dr = 1;
    end else if (data_read) begin
      m_dr = 0; m_ov = 0;
    end
    hist.push_front(serial_in);
    void'(hist.pop_back());
    cyc++;
  endtask

  // Compare process: advance the model on each edge, check all outputs 1 ns later.
  always @(posedge clk) begin
    if (!n_rst) model_reset();
    else        model_step();
    #1;
    check("sbc_clear",     sbc_clear,     busy && (cyc == t0));
    check("enable_timer",  enable_timer,  busy && (cyc > t0) && (td < 0));
    check("load_buffer",   load_buffer,   busy && (td >= 0) && (cyc == td + 2));
    check("data_ready",    data_ready,    m_dr);
    check("framing_error", framing_error, m_fe);
    check("overrun_error", overrun_error, m_ov);
    cnt_sbc  += int'(sbc_clear);
    cnt_en   += int'(enable_timer);
    cnt_load += int'(load_buffer);
  end

  // One packet: fall, optional line toggling, packet_done in RECEIVE cycle ncyc.
  task automatic packet(input logic stop, input logic rd_load, input int ncyc);
    int waited = 0;
    stop_bit = stop;
    @(negedge clk) serial_in = 1'b0;
    while (!enable_timer && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("receive_entered", enable_timer, 1'b1);
    for (int i = 2; i <= ncyc; i++) begin
      @(negedge clk);
      if (i < ncyc - 5) serial_in = 1'($urandom_range(0, 1));
      else              serial_in = 1'b1;
    end
    packet_done = 1'b1;
    @(negedge clk) packet_done = 1'b0;
    @(negedge clk) data_read = rd_load;
    @(negedge clk) data_read = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  int s_sbc, s_en, s_load;

  initial begin
    serial_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", sbc_clear | enable_timer | load_buffer | data_ready |
                         framing_error | overrun_error, 1'b0);
    serial_in = 1'b1;
    @(negedge clk) n_rst = 1'b1;
    repeat (5) @(negedge clk);
    check_int("idle_no_start", cnt_sbc, 0);

    // Good packet with a 90-cycle receive phase.
    s_sbc = cnt_sbc; s_en = cnt_en; s_load = cnt_load;
    packet(1'b1, 1'b0, 90);
    check_int("good_sbc_pulses", cnt_sbc - s_sbc, 1);
    check_int("good_en_cycles",  cnt_en - s_en, 90);
    check_int("good_load_pulses", cnt_load - s_load, 1);
    check("good_ready", data_ready, 1'b1);
    check("good_fe",    framing_error, 1'b0);
    check("good_ov",    overrun_error, 1'b0);

    // Bad stop bit: framing error, no load, ready untouched.
    s_load = cnt_load;
    packet(1'b0, 1'b0, 90);
    check("frm_fe", framing_error, 1'b1);
    check_int("frm_no_load", cnt_load - s_load, 0);
    check("frm_ready", data_ready, 1'b1);

    // Second load without a read: overrun; next start clears framing.
    packet(1'b1, 1'b0, 50);
    check("ovr_fe_cleared", framing_error, 1'b0);
    check("ovr_ready", data_ready, 1'b1);
    check("ovr_ov", overrun_error, 1'b1);
    @(negedge clk) data_read = 1'b1;
    @(negedge clk) data_read = 1'b0;
    check("read_ready", data_ready, 1'b0);
    check("read_ov", overrun_error, 1'b0);

    // data_read in the LOAD cycle while ready: no overrun.
    packet(1'b1, 1'b0, 20);
    packet(1'b1, 1'b1, 20);
    check("simul_ready", data_ready, 1'b1);
    check("simul_ov", overrun_error, 1'b0);

    // Reset in the middle of RECEIVE.
    s_load = cnt_load;
    @(negedge clk) serial_in = 1'b0;
    repeat (S + 4) @(negedge clk);
    check("mid_in_receive", enable_timer, 1'b1);
    n_rst = 1'b0;
    #1;
    check("mid_rst_en", enable_timer, 1'b0);
    check("mid_rst_ready", data_ready, 1'b0);
    serial_in = 1'b1;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (10) @(negedge clk);
    check_int("mid_no_load", cnt_load - s_load, 0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) serial_in = ~serial_in;
      packet_done = ($urandom_range(0, 39) == 0);
      stop_bit    = ($urandom_range(0, 3) != 0);
      data_read   = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 1499) == 0) n_rst = 1'b0;
      else if (!n_rst && $urandom_range(0, 1) == 0) n_rst = 1'b1;
    end
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
